// File: rtl/i2c_cfg_pkg.sv
// rtl/i2c_cfg_pkg.sv - shared states, constants and counter helper for the I2C config sequencer
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_LOAD,
    ST_GO_HI,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } seq_state_t;

  localparam logic [7:0] BYTE_NUM_C         = 8'd2;
  localparam logic [7:0] DEFAULT_SLAVE_ADDR = 8'h72;
  localparam int         GO_HI_CYCLES       = 2;

  // True on the final cycle of a phase that lasts 'limit' cycles, counting from cnt=0.
  function automatic logic cnt_last(input logic [31:0] cnt, input int limit);
    return (cnt + 32'd1) >= 32'(limit);
  endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// rtl/i2c_config_rom.sv - combinational {register, data} table for HDMI transmitter bring-up
module i2c_config_rom #(
  parameter int NUM_REGS = 31
) (
  input  logic [5:0]  index,
  output logic [15:0] entry
);

  logic [15:0] raw;

  always_comb begin
    raw = 16'h0000;
    case (index)
      6'd0:  raw = 16'h9803;
      6'd1:  raw = 16'h0100;
      6'd2:  raw = 16'h0218;
      6'd3:  raw = 16'h0300;
      6'd4:  raw = 16'h1470;
      6'd5:  raw = 16'h1520;
      6'd6:  raw = 16'h1630;
      6'd7:  raw = 16'h1846;
      6'd8:  raw = 16'h4080;
      6'd9:  raw = 16'h4110;
      6'd10: raw = 16'h49A8;
      6'd11: raw = 16'h5510;
      6'd12: raw = 16'h5608;
      6'd13: raw = 16'h96F6;
      6'd14: raw = 16'h7307;
      6'd15: raw = 16'h761F;
      6'd16: raw = 16'h9803;
      6'd17: raw = 16'h9902;
      6'd18: raw = 16'h9AE0;
      6'd19: raw = 16'h9C30;
      6'd20: raw = 16'h9D61;
      6'd21: raw = 16'hA2A4;
      6'd22: raw = 16'hA3A4;
      6'd23: raw = 16'hA504;
      6'd24: raw = 16'hAB40;
      6'd25: raw = 16'hAF16;
      6'd26: raw = 16'hBA60;
      6'd27: raw = 16'hD1FF;
      6'd28: raw = 16'hDE10;
      6'd29: raw = 16'hE460;
      6'd30: raw = 16'hFA7D;
      default: raw = 16'h0000;
    endcase
    // Entries past the configured table length read as zero.
    entry = (32'(index) < 32'(NUM_REGS)) ? raw : 16'h0000;
  end

endmodule

// File: rtl/i2c_config_seq.sv
// rtl/i2c_config_seq.sv - walks the register table, issuing one I2C write per entry with retry
module i2c_config_seq
  import i2c_cfg_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR   = DEFAULT_SLAVE_ADDR,
  parameter int         NUM_REGS     = 31,
  parameter int         PWRUP_CYCLES = 1000,
  parameter int         GAP_CYCLES   = 16,
  parameter int         MAX_RETRY    = 3,
  parameter int         TIMEOUT      = 4096
) (
  input  logic        PT_CK,
  input  logic        RESET,
  input  logic        START,
  input  logic        END_OK,
  input  logic        ACK_OK,
  output logic        GO,
  output logic [15:0] REG_DATA,
  output logic [7:0]  SLAVE_ADDRESS,
  output logic [7:0]  BYTE_NUM,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAIL,
  output logic [5:0]  INDEX,
  output logic [7:0]  RETRY_TOTAL
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_REGS - 1);

  seq_state_t  state, state_nxt;
  logic        start_q;
  logic        start_rise;
  logic [31:0] cnt;
  logic [7:0]  retry_cnt;
  logic        nack;
  logic        retry_ok;
  logic [15:0] rom_data;

  assign start_rise    = START & ~start_q;
  assign retry_ok      = 32'(retry_cnt) < 32'(MAX_RETRY);
  assign SLAVE_ADDRESS = SLAVE_ADDR;
  assign BYTE_NUM      = BYTE_NUM_C;

  i2c_config_rom #(
    .NUM_REGS (NUM_REGS)
  ) u_rom (
    .index (INDEX),
    .entry (rom_data)
  );

  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    GO        = 1'b0;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    FAIL      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        BUSY = 1'b0;
        DONE = (state == ST_DONE);
        FAIL = (state == ST_FAIL);
        if (start_rise) state_nxt = ST_PWRUP;
      end
      ST_PWRUP:     if (cnt_last(cnt, PWRUP_CYCLES)) state_nxt = ST_LOAD;
      ST_LOAD:      state_nxt = ST_GO_HI;
      ST_GO_HI: begin
        GO = 1'b1;
        if (cnt_last(cnt, GO_HI_CYCLES)) state_nxt = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!END_OK)                      state_nxt = ST_WAIT_HIGH;
        else if (cnt_last(cnt, TIMEOUT))  state_nxt = ST_CHECK;
      end
      ST_WAIT_HIGH: if (END_OK || cnt_last(cnt, TIMEOUT)) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!nack)         state_nxt = (INDEX == LAST_IDX) ? ST_DONE : ST_GAP;
        else if (retry_ok) state_nxt = ST_GAP;
        else               state_nxt = ST_FAIL;
      end
      ST_GAP:       if (cnt_last(cnt, GAP_CYCLES)) state_nxt = ST_LOAD;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      start_q     <= 1'b0;
      cnt         <= '0;
      retry_cnt   <= '0;
      nack        <= 1'b0;
      INDEX       <= '0;
      RETRY_TOTAL <= '0;
      REG_DATA    <= '0;
    end else begin
      start_q <= START;

      // Every timed phase starts from zero on entry.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state inside {ST_PWRUP, ST_GO_HI, ST_WAIT_LOW, ST_WAIT_HIGH, ST_GAP}) begin
        cnt <= cnt + 32'd1;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start_rise) begin
            INDEX       <= '0;
            RETRY_TOTAL <= '0;
            retry_cnt   <= '0;
          end
        end
        ST_LOAD: REG_DATA <= rom_data;
        ST_WAIT_LOW: begin
          if (END_OK && cnt_last(cnt, TIMEOUT)) nack <= 1'b1;
        end
        ST_WAIT_HIGH: begin
          if (END_OK)                      nack <= ACK_OK;
          else if (cnt_last(cnt, TIMEOUT)) nack <= 1'b1;
        end
        ST_CHECK: begin
          if (!nack) begin
            if (INDEX != LAST_IDX) begin
              INDEX     <= INDEX + 6'd1;
              retry_cnt <= '0;
            end
          end else if (retry_ok) begin
            retry_cnt <= retry_cnt + 8'd1;
            if (RETRY_TOTAL != 8'hFF) RETRY_TOTAL <= RETRY_TOTAL + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_seq.sv
// tb/tb_i2c_config_seq.sv - scoreboard bench for the I2C config sequencer with a writer model
module tb_i2c_config_seq;

  logic        PT_CK;
  logic        RESET;
  logic        START;
  logic        END_OK;
  logic        ACK_OK;
  logic        GO;
  logic [15:0] REG_DATA;
  logic [7:0]  SLAVE_ADDRESS;
  logic [7:0]  BYTE_NUM;
  logic        BUSY;
  logic        DONE;
  logic        FAIL;
  logic [5:0]  INDEX;
  logic [7:0]  RETRY_TOTAL;

  localparam logic [15:0] E0 = 16'h9803;
  localparam logic [15:0] E1 = 16'h0100;
  localparam logic [15:0] E2 = 16'h0218;

  typedef struct packed {
    logic [15:0] data;
    logic [5:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   mode;
  bit   release_wr;
  bit   nack_used;
  int   go_count;
  int   last_low_len;

  i2c_config_seq #(
    .NUM_REGS     (3),
    .PWRUP_CYCLES (10),
    .GAP_CYCLES   (4),
    .MAX_RETRY    (3),
    .TIMEOUT      (64)
  ) dut (
    .PT_CK         (PT_CK),
    .RESET         (RESET),
    .START         (START),
    .END_OK        (END_OK),
    .ACK_OK        (ACK_OK),
    .GO            (GO),
    .REG_DATA      (REG_DATA),
    .SLAVE_ADDRESS (SLAVE_ADDRESS),
    .BYTE_NUM      (BYTE_NUM),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .FAIL          (FAIL),
    .INDEX         (INDEX),
    .RETRY_TOTAL   (RETRY_TOTAL)
  );

  initial PT_CK = 1'b0;
  always #5 PT_CK = ~PT_CK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [5:0] i);
    exp_t e;
    e.data = d;
    e.idx  = i;
    sb.push_back(e);
  endtask

  // Monitor: every GO rising edge must match the next scoreboard entry.
  initial begin : monitor
    logic go_prev;
    int   high_len;
    int   low_len;
    exp_t e;
    go_prev  = 1'b0;
    high_len = 0;
    low_len  = 0;
    forever begin
      @(negedge PT_CK);
      if (GO === 1'b1) begin
        if (!go_prev) begin
          last_low_len = low_len;
          go_count++;
          chk("go_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("go_reg_data", 32'(REG_DATA), 32'(e.data));
            chk("go_index", 32'(INDEX), 32'(e.idx));
          end
          high_len = 0;
        end
        high_len++;
        low_len = 0;
      end else begin
        if (go_prev) chk("go_width", high_len, 2);
        low_len++;
      end
      go_prev = (GO === 1'b1);
    end
  end

  // Writer model: END_OK drops after GO, then rises with the ack/nack verdict.
  initial begin : writer
    int idx;
    END_OK    = 1'b1;
    ACK_OK    = 1'b0;
    nack_used = 1'b0;
    forever begin
      @(negedge PT_CK);
      if (GO === 1'b1 && !RESET) begin
        idx = int'(INDEX);
        for (int i = 0; i < 20 && GO === 1'b1; i++) @(negedge PT_CK);
        if (mode != 3) begin
          repeat (2) @(negedge PT_CK);
          END_OK = 1'b0;
          if (mode == 4) begin
            for (int i = 0; i < 3000 && !release_wr; i++) @(negedge PT_CK);
          end else begin
            repeat (4) @(negedge PT_CK);
          end
          ACK_OK = (mode == 2 && idx == 1) || (mode == 1 && idx == 1 && !nack_used);
          if (mode == 1 && idx == 1) nack_used = 1'b1;
          END_OK = 1'b1;
          @(negedge PT_CK);
          ACK_OK = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_go"},       32'(GO),          32'd0);
    chk({tag, "_busy"},     32'(BUSY),        32'd0);
    chk({tag, "_done"},     32'(DONE),        32'd0);
    chk({tag, "_fail"},     32'(FAIL),        32'd0);
    chk({tag, "_index"},    32'(INDEX),       32'd0);
    chk({tag, "_retries"},  32'(RETRY_TOTAL), 32'd0);
    chk({tag, "_reg_data"}, 32'(REG_DATA),    32'd0);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    repeat (2) @(negedge PT_CK);
    chk("busy_after_start", 32'(BUSY), 32'd1);
    START = 1'b0;
  endtask

  task automatic wait_end_and_check(input string tag, input logic done_e, input logic fail_e,
                                    input logic [5:0] idx_e, input logic [7:0] rt_e);
    for (int i = 0; i < 5000 && !(DONE === 1'b1 || FAIL === 1'b1); i++) @(negedge PT_CK);
    chk({tag, "_terminated"}, 32'(DONE === 1'b1 || FAIL === 1'b1), 32'd1);
    repeat (40) @(negedge PT_CK);
    chk({tag, "_done"},    32'(DONE),        32'(done_e));
    chk({tag, "_fail"},    32'(FAIL),        32'(fail_e));
    chk({tag, "_busy"},    32'(BUSY),        32'd0);
    chk({tag, "_index"},   32'(INDEX),       32'(idx_e));
    chk({tag, "_retries"}, 32'(RETRY_TOTAL), 32'(rt_e));
    chk({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin : main
    int gc;
    checks     = 0;
    errors     = 0;
    mode       = 0;
    release_wr = 1'b0;
    go_count   = 0;
    RESET      = 1'b1;
    START      = 1'b0;
    repeat (3) @(negedge PT_CK);
    check_reset_outputs("reset");
    chk("slave_address", 32'(SLAVE_ADDRESS), 32'h72);
    chk("byte_num",      32'(BYTE_NUM),      32'd2);
    RESET = 1'b0;
    repeat (2) @(negedge PT_CK);

    mode = 0;
    push(E0, 0); push(E1, 1); push(E2, 2);
    pulse_start();
    wait_end_and_check("all_ack", 1'b1, 1'b0, 6'd2, 8'd0);

    mode = 1;
    push(E0, 0); push(E1, 1); push(E1, 1); push(E2, 2);
    pulse_start();
    wait_end_and_check("nack_once", 1'b1, 1'b0, 6'd2, 8'd1);

    mode = 2;
    push(E0, 0); push(E1, 1); push(E1, 1); push(E1, 1); push(E1, 1);
    pulse_start();
    wait_end_and_check("nack_always", 1'b0, 1'b1, 6'd1, 8'd3);

    mode = 3;
    repeat (4) push(E0, 0);
    pulse_start();
    wait_end_and_check("timeout", 1'b0, 1'b1, 6'd0, 8'd3);
    chk("timeout_reissue_gap", last_low_len, 70);

    mode = 4;
    push(E0, 0);
    gc = go_count;
    pulse_start();
    for (int i = 0; i < 200 && go_count == gc; i++) @(negedge PT_CK);
    chk("rst_go_seen", 32'(go_count != gc), 32'd1);
    repeat (12) @(negedge PT_CK);
    RESET = 1'b1;
    @(negedge PT_CK);
    check_reset_outputs("mid_reset");
    RESET = 1'b0;
    release_wr = 1'b1;
    repeat (40) @(negedge PT_CK);
    release_wr = 1'b0;
    mode = 0;
    chk("no_go_after_reset", go_count, gc + 1);
    push(E0, 0); push(E1, 1); push(E2, 2);
    pulse_start();
    wait_end_and_check("restart", 1'b1, 1'b0, 6'd2, 8'd0);

    push(E0, 0); push(E1, 1); push(E2, 2);
    START = 1'b1;
    for (int k = 0; k < 5; k++) begin
      repeat (3) @(negedge PT_CK);
      START = 1'b0;
      repeat (3) @(negedge PT_CK);
      START = 1'b1;
    end
    @(negedge PT_CK);
    START = 1'b0;
    wait_end_and_check("start_while_busy", 1'b1, 1'b0, 6'd2, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_config_seq.md
I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 8'h72, the 8-bit write address driven on SLAVE_ADDRESS.
REQ-002 SHALL have parameter NUM_REGS, default 31, the number of table entries, range 1..64.
REQ-003 SHALL have parameter PWRUP_CYCLES, default 1000, the idle cycles after START before the first write.
REQ-004 SHALL have parameter GAP_CYCLES, default 16, the idle cycles between consecutive writes.
REQ-005 SHALL have parameter MAX_RETRY, default 3, the re-attempts allowed per entry after a NACK or timeout.
REQ-006 SHALL have parameter TIMEOUT, default 4096, the cycles allowed for each END_OK wait phase.
REQ-007 PT_CK  in  1  clock; one clock domain; all logic on the rising edge.
REQ-008 RESET  in  1  synchronous, active-high reset.
REQ-009 START  in  1  level; a rising edge sampled in IDLE, DONE or FAIL launches a full configuration pass.
REQ-010 END_OK  in  1  writer status; high = writer idle/finished, low = transaction in progress.
REQ-011 ACK_OK  in  1  writer flag; high = slave NACKed some byte; valid on the cycle END_OK rises.
REQ-012 GO  out  1  write request to the writer.
REQ-013 REG_DATA  out  16  {register, data} for the current entry.
REQ-014 SLAVE_ADDRESS  out  8  constant SLAVE_ADDR.
REQ-015 BYTE_NUM  out  8  constant 8'd2.
REQ-016 BUSY  out  1  high from the START edge until DONE or FAIL.
REQ-017 DONE  out  1  high when all entries were written; held until the next START.
REQ-018 FAIL  out  1  high when an entry exhausted its retries; held until the next START.
REQ-019 INDEX  out  6  the current entry; on FAIL, the failing entry.
REQ-020 RETRY_TOTAL  out  8  retries in this pass; saturates at 255.

Function
REQ-021 SHALL implement states IDLE, PWRUP, LOAD, GO_HI, WAIT_LOW, WAIT_HIGH, CHECK, GAP, DONE and FAIL.
REQ-022 IDLE/DONE/FAIL -> PWRUP on a START rising edge; this clears INDEX, RETRY_TOTAL, DONE, FAIL and the per-entry retry count.
REQ-023 PWRUP SHALL count PWRUP_CYCLES cycles, then go to LOAD.
REQ-024 LOAD SHALL register REG_DATA from the table at INDEX for one cycle, then go to GO_HI; REG_DATA is stable from LOAD until the next LOAD.
REQ-025 GO_HI SHALL hold GO=1 for exactly 2 cycles, then drive GO=0 and go to WAIT_LOW; GO is never high in any other state.
REQ-026 WAIT_LOW SHALL wait for END_OK==0, then go to WAIT_HIGH.
REQ-027 WAIT_HIGH SHALL wait for END_OK==1; on that cycle it latches ACK_OK as the nack bit and goes to CHECK.
REQ-028 Each wait phase SHALL restart a timeout counter; reaching TIMEOUT counts as a failed attempt and goes to CHECK with nack=1.
REQ-029 CHECK, nack=0: if INDEX==NUM_REGS-1 go to DONE, else increment INDEX, clear the retry count and go to GAP.
REQ-030 CHECK, nack=1: if retry count < MAX_RETRY, increment it and RETRY_TOTAL and go to GAP keeping INDEX; else go to FAIL.
REQ-031 GAP SHALL count GAP_CYCLES cycles, then go to LOAD.
REQ-032 START edges while BUSY SHALL be ignored.
REQ-033 START edge detection SHALL use a registered copy of START, cleared by reset.
REQ-034 No arithmetic SHALL wrap: INDEX never exceeds NUM_REGS-1, and RETRY_TOTAL saturates at 255.

Reset
REQ-035 When RESET is high at a clock edge, SHALL enter IDLE and drive GO=0, BUSY=0, DONE=0, FAIL=0, INDEX=0, RETRY_TOTAL=0 and REG_DATA=0.
REQ-036 A reset mid-transaction SHALL drop GO on the next edge; no further writes are issued until a new START edge.

Structure
REQ-037 Package i2c_cfg_pkg SHALL hold the state enumeration, the BYTE_NUM constant 2 and the default SLAVE_ADDR.
REQ-038 The register table SHALL be sub-module i2c_config_rom: combinational, 6-bit index in, 16-bit entry out, NUM_REGS entries for HDMI transmitter bring-up.

Verification
REQ-039 NUM_REGS=3, writer model always ACKs -> exactly 3 GO pulses carrying table entries 0,1,2 in order, then DONE=1, BUSY=0, RETRY_TOTAL=0.
REQ-040 Model NACKs entry 1 once -> entry 1 issued twice, DONE=1, RETRY_TOTAL=1.
REQ-041 Model NACKs entry 1 on every attempt, MAX_RETRY=3 -> 4 GO pulses for entry 1, then FAIL=1, INDEX=1, entry 2 never issued.
REQ-042 END_OK held high after GO, TIMEOUT=64 -> WAIT_LOW times out after 64 cycles, GO is reissued, and FAIL follows after MAX_RETRY+1 attempts.
REQ-043 RESET pulsed while in WAIT_HIGH -> GO=0 and IDLE next cycle, all outputs at reset values, and a new START restarts at INDEX=0.
REQ-044 START toggled while BUSY -> no effect; pass completes unchanged with DONE=1.
